// File: rtl/ghostbus_arbiter_pkg.sv
// Shared definitions for the ghostbus two-requester arbiter:
// FSM state encodings and the WAIT counter width.
package ghostbus_arbiter_pkg;

    localparam int RD_CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/ghostbus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the requester that did not win last time.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = req;
        if (&req) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ghostbus_arbiter.sv
// Arbitrates two req/ack requesters onto one ghostbus host port, issuing
// single-beat writes and fixed-latency reads with registered outputs.
module ghostbus_arbiter
    import ghostbus_arbiter_pkg::*;
#(
    parameter int GB_AW = 24,
    parameter int GB_DW = 32,
    parameter int RD    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           m_req,
    input  logic [1:0]           m_we,
    input  logic [2*GB_AW-1:0]   m_addr,
    input  logic [2*GB_DW-1:0]   m_wdata,
    output logic [1:0]           m_ack,
    output logic [GB_DW-1:0]     m_rdata,
    output logic [1:0]           m_grant,
    output logic [GB_AW-1:0]     gb_addr,
    output logic [GB_DW-1:0]     gb_wdata,
    output logic                 gb_wen,
    output logic                 gb_rstb,
    input  logic [GB_DW-1:0]     gb_rdata
);

    state_t             state_reg, state_next;
    logic [RD_CW-1:0]   cnt_reg, cnt_next;
    logic               we_reg, we_next;
    logic               last_reg, last_next;

    logic [1:0]         ack_next;
    logic [GB_DW-1:0]   rdata_next;
    logic [1:0]         grant_next;
    logic [GB_AW-1:0]   addr_next;
    logic [GB_DW-1:0]   wdata_next;
    logic               wen_next, rstb_next;

    logic [1:0]         pick_gnt;
    logic               pick_valid;
    logic               win;

    logic [GB_AW-1:0]   req_addr  [2];
    logic [GB_DW-1:0]   req_wdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req_addr[gi]  = m_addr[gi*GB_AW +: GB_AW];
            assign req_wdata[gi] = m_wdata[gi*GB_DW +: GB_DW];
        end
    endgenerate

    rr_pick2 u_pick (
        .req   (m_req),
        .last  (last_reg),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign win = pick_gnt[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        last_next  = last_reg;
        ack_next   = 2'b00;
        rdata_next = m_rdata;
        grant_next = m_grant;
        addr_next  = gb_addr;
        wdata_next = gb_wdata;
        wen_next   = 1'b0;
        rstb_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    addr_next  = req_addr[win];
                    wdata_next = req_wdata[win];
                    we_next    = m_we[win];
                    grant_next = pick_gnt;
                    last_next  = win;
                    // Strobes are registered, so they are set up here to be
                    // visible during the ISSUE cycle.
                    wen_next   = m_we[win];
                    rstb_next  = ~m_we[win];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    ack_next   = m_grant;
                    state_next = ACK;
                end else if (RD == 0) begin
                    rdata_next = gb_rdata;
                    ack_next   = m_grant;
                    state_next = ACK;
                end else begin
                    cnt_next   = RD_CW'(RD);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - RD_CW'(1);
                if (cnt_reg == RD_CW'(1)) begin
                    rdata_next = gb_rdata;
                    ack_next   = m_grant;
                    state_next = ACK;
                end
            end
            ACK: begin
                grant_next = 2'b00;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            last_reg  <= 1'b1;
            m_ack     <= 2'b00;
            m_rdata   <= '0;
            m_grant   <= 2'b00;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_wen    <= 1'b0;
            gb_rstb   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            last_reg  <= last_next;
            m_ack     <= ack_next;
            m_rdata   <= rdata_next;
            m_grant   <= grant_next;
            gb_addr   <= addr_next;
            gb_wdata  <= wdata_next;
            gb_wen    <= wen_next;
            gb_rstb   <= rstb_next;
        end
    end

endmodule
